// File: rtl/vpp_cond_stack.sv
// Preprocessor conditional-compilation tracker: evaluates `ifdef/`elsif/`else/`endif
// nesting against a macro define table and emits one registered beat per token.
module vpp_cond_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ID_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_op,
  output logic [ID_W-1:0] out_id,
  output logic            out_active,
  output logic [3:0]      depth,
  output logic            err,
  output logic [1:0]      err_code,
  input  logic            err_clr
);

  localparam int unsigned NDEF = 1 << ID_W;
  // Stack storage is sized to the full 4-bit depth range so any depth value indexes it directly.
  localparam int unsigned SW   = 16;

  localparam logic [2:0] OP_TEXT   = 3'd0;
  localparam logic [2:0] OP_DEFINE = 3'd1;
  localparam logic [2:0] OP_UNDEF  = 3'd2;
  localparam logic [2:0] OP_IFDEF  = 3'd3;
  localparam logic [2:0] OP_IFNDEF = 3'd4;
  localparam logic [2:0] OP_ELSIF  = 3'd5;
  localparam logic [2:0] OP_ELSE   = 3'd6;
  localparam logic [2:0] OP_ENDIF  = 3'd7;

  localparam logic [1:0] E_UNDER = 2'd1;
  localparam logic [1:0] E_OVER  = 2'd2;
  localparam logic [1:0] E_ORDER = 2'd3;

  logic [NDEF-1:0] def_q, def_d;
  logic [SW-1:0]   par_q, par_d;
  logic [SW-1:0]   cur_q, cur_d;
  logic [SW-1:0]   tkn_q, tkn_d;
  logic [SW-1:0]   els_q, els_d;
  logic [3:0]      depth_q, depth_d;
  logic            out_valid_q, out_valid_d;
  logic [2:0]      out_op_q, out_op_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic            out_active_q, out_active_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic       accept;
  logic       act;
  logic       new_act;
  logic       br;
  logic       err_hit;
  logic [1:0] hit_code;
  logic [3:0] top;
  logic [3:0] below;

  assign in_ready   = ~out_valid_q | out_ready;
  assign accept     = in_valid & in_ready;
  assign out_valid  = out_valid_q;
  assign out_op     = out_op_q;
  assign out_id     = out_id_q;
  assign out_active = out_active_q;
  assign depth      = depth_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

  // Token evaluation: stack/define-table update, error detection and output beat.
  always_comb begin
    def_d        = def_q;
    par_d        = par_q;
    cur_d        = cur_q;
    tkn_d        = tkn_q;
    els_d        = els_q;
    depth_d      = depth_q;
    out_valid_d  = out_valid_q;
    out_op_d     = out_op_q;
    out_id_d     = out_id_q;
    out_active_d = out_active_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    err_hit      = 1'b0;
    hit_code     = 2'd0;
    br           = 1'b0;
    top          = depth_q - 4'd1;
    below        = depth_q - 4'd2;
    act          = (depth_q == 4'd0) ? 1'b1 : cur_q[top];
    new_act      = act;

    if (accept) begin
      case (in_op)
        OP_TEXT: begin
        end
        OP_DEFINE: if (act) def_d[in_id] = 1'b1;
        OP_UNDEF:  if (act) def_d[in_id] = 1'b0;
        OP_IFDEF, OP_IFNDEF: begin
          if (depth_q == 4'(DEPTH)) begin
            err_hit  = 1'b1;
            hit_code = E_OVER;
          end else begin
            br             = act & (def_q[in_id] ^ (in_op == OP_IFNDEF));
            par_d[depth_q] = act;
            cur_d[depth_q] = br;
            tkn_d[depth_q] = br;
            els_d[depth_q] = 1'b0;
            depth_d        = depth_q + 4'd1;
            new_act        = br;
          end
        end
        OP_ELSIF, OP_ELSE: begin
          if (depth_q == 4'd0) begin
            err_hit  = 1'b1;
            hit_code = E_UNDER;
          end else if (els_q[top]) begin
            err_hit  = 1'b1;
            hit_code = E_ORDER;
          end else begin
            br         = par_q[top] & ~tkn_q[top] & ((in_op == OP_ELSE) | def_q[in_id]);
            cur_d[top] = br;
            tkn_d[top] = tkn_q[top] | br | (in_op == OP_ELSE);
            els_d[top] = (in_op == OP_ELSE);
            new_act    = br;
          end
        end
        OP_ENDIF: begin
          if (depth_q == 4'd0) begin
            err_hit  = 1'b1;
            hit_code = E_UNDER;
          end else begin
            depth_d = top;
            new_act = (depth_q == 4'd1) ? 1'b1 : cur_q[below];
          end
        end
        default: begin
        end
      endcase
      out_valid_d  = 1'b1;
      out_op_d     = in_op;
      out_id_d     = in_id;
      out_active_d = new_act;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A new error beats a simultaneous clear; otherwise only the first code is kept.
    if (err_hit) begin
      err_d      = 1'b1;
      err_code_d = (err_q && !err_clr) ? err_code_q : hit_code;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      def_q        <= '0;
      par_q        <= '0;
      cur_q        <= '0;
      tkn_q        <= '0;
      els_q        <= '0;
      depth_q      <= 4'd0;
      out_valid_q  <= 1'b0;
      out_op_q     <= 3'd0;
      out_id_q     <= '0;
      out_active_q <= 1'b1;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      def_q        <= def_d;
      par_q        <= par_d;
      cur_q        <= cur_d;
      tkn_q        <= tkn_d;
      els_q        <= els_d;
      depth_q      <= depth_d;
      out_valid_q  <= out_valid_d;
      out_op_q     <= out_op_d;
      out_id_q     <= out_id_d;
      out_active_q <= out_active_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_vpp_cond_stack.sv
// Directed bench for vpp_cond_stack: nesting, define gating, errors, backpressure, reset.
module tb_vpp_cond_stack;

  localparam logic [2:0] TEXT = 3'd0, DEFINE = 3'd1, UNDEF = 3'd2, IFDEF = 3'd3,
                         IFNDEF = 3'd4, ELSIF = 3'd5, ELSE = 3'd6, ENDIF = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [2:0] in_op;
  logic [3:0] in_id;
  logic       out_valid, out_ready;
  logic [2:0] out_op;
  logic [3:0] out_id;
  logic       out_active;
  logic [3:0] depth;
  logic       err;
  logic [1:0] err_code;
  logic       err_clr;

  int n_chk = 0;
  int n_err = 0;

  vpp_cond_stack #(.DEPTH(8), .ID_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_id(out_id),
    .out_active(out_active), .depth(depth), .err(err), .err_code(err_code),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One token with out_ready high; checks the resulting beat.
  task automatic send(input logic [2:0] op, input logic [3:0] id, input logic exp_act,
                      input logic [3:0] exp_dep, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_id    = id;
    #1 chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"}, 32'(out_op), 32'(op));
    chk({tag, ".act"}, 32'(out_active), 32'(exp_act));
    chk({tag, ".dep"}, 32'(depth), 32'(exp_dep));
  endtask

  task automatic chk_err(input logic exp_e, input logic [1:0] exp_c, input string tag);
    chk({tag, ".err"}, 32'(err), 32'(exp_e));
    chk({tag, ".code"}, 32'(err_code), 32'(exp_c));
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  logic [2:0] bop [4];
  logic [3:0] bid [4];
  logic       bact[4];

  initial begin
    int ti, bi;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_id = 4'd0;
    out_ready = 1'b1; err_clr = 1'b0;
    bop = '{DEFINE, IFNDEF, TEXT, ENDIF};
    bid = '{4'd7, 4'd7, 4'd9, 4'd0};
    bact = '{1'b1, 1'b0, 1'b0, 1'b1};

    #12;
    chk("rst.vld", 32'(out_valid), 32'd0);
    chk("rst.dep", 32'(depth), 32'd0);
    chk("rst.act", 32'(out_active), 32'd1);
    chk("rst.op", 32'(out_op), 32'd0);
    chk("rst.id", 32'(out_id), 32'd0);
    chk_err(1'b0, 2'd0, "rst");
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst.rdy", 32'(in_ready), 32'd1);

    // Basic if/elsif/else chain
    send(DEFINE, 4'd3, 1'b1, 4'd0, "chain.def3");
    send(IFDEF,  4'd1, 1'b0, 4'd1, "chain.ifdef1");
    send(ELSIF,  4'd3, 1'b1, 4'd1, "chain.elsif3");
    chk("chain.id", 32'(out_id), 32'd3);
    send(ELSE,   4'd0, 1'b0, 4'd1, "chain.else");
    send(ENDIF,  4'd0, 1'b1, 4'd0, "chain.endif");
    chk_err(1'b0, 2'd0, "chain");

    // DEFINE inside an inactive region is ignored
    send(IFDEF,  4'd5, 1'b0, 4'd1, "gate.ifdef5");
    send(DEFINE, 4'd5, 1'b0, 4'd1, "gate.def5");
    send(ENDIF,  4'd0, 1'b1, 4'd0, "gate.endif");
    send(IFDEF,  4'd5, 1'b0, 4'd1, "gate.ifdef5b");
    send(ENDIF,  4'd0, 1'b1, 4'd0, "gate.endif2");

    // UNDEF in an active region takes effect
    send(UNDEF,  4'd3, 1'b1, 4'd0, "undef.u3");
    send(IFDEF,  4'd3, 1'b0, 4'd1, "undef.ifdef3");
    send(ENDIF,  4'd0, 1'b1, 4'd0, "undef.endif");

    // Overflow then underflow; first code sticks
    for (int i = 1; i <= 8; i++) send(IFNDEF, 4'd0, 1'b1, 4'(i), "ovf.push");
    chk_err(1'b0, 2'd0, "ovf.pre");
    send(IFNDEF, 4'd0, 1'b1, 4'd8, "ovf.ninth");
    chk_err(1'b1, 2'd2, "ovf.ninth");
    for (int i = 7; i >= 0; i--) send(ENDIF, 4'd0, 1'b1, 4'(i), "ovf.pop");
    send(ENDIF, 4'd0, 1'b1, 4'd0, "ovf.under");
    chk_err(1'b1, 2'd2, "ovf.under");
    clr_pulse();
    chk_err(1'b0, 2'd0, "ovf.clr");

    // Double ELSE is an order error; state unchanged
    send(IFDEF, 4'd2, 1'b0, 4'd1, "ord.ifdef2");
    send(ELSE,  4'd0, 1'b1, 4'd1, "ord.else1");
    send(ELSE,  4'd0, 1'b1, 4'd1, "ord.else2");
    chk_err(1'b1, 2'd3, "ord.else2");
    send(ELSIF, 4'd3, 1'b1, 4'd1, "ord.elsif");
    chk_err(1'b1, 2'd3, "ord.elsif");
    send(ENDIF, 4'd0, 1'b1, 4'd0, "ord.endif");

    // Error in the same cycle as err_clr wins and recaptures the code
    @(negedge clk);
    in_valid = 1'b1; in_op = ENDIF; in_id = 4'd0; err_clr = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; err_clr = 1'b0;
    chk_err(1'b1, 2'd1, "clrwin");
    chk("clrwin.dep", 32'(depth), 32'd0);
    clr_pulse();
    chk_err(1'b0, 2'd0, "clrwin.clr");

    // Backpressure: out_ready low for three cycles after the first beat
    ti = 0; bi = 0;
    for (int cyc = 0; cyc < 30 && bi < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid  = (ti < 4);
      if (ti < 4) begin
        in_op = bop[ti];
        in_id = bid[ti];
      end
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        chk("bp.stall_rdy", 32'(in_ready), 32'd0);
        chk("bp.hold_id", 32'(out_id), 32'(bid[0]));
        chk("bp.hold_vld", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        chk("bp.op", 32'(out_op), 32'(bop[bi]));
        chk("bp.id", 32'(out_id), 32'(bid[bi]));
        chk("bp.act", 32'(out_active), 32'(bact[bi]));
        bi++;
      end
      if (in_valid && in_ready) ti++;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    chk("bp.beats", 32'(bi), 32'd4);
    chk("bp.tokens", 32'(ti), 32'd4);
    chk("bp.dep", 32'(depth), 32'd0);
    out_ready = 1'b1;

    // Asynchronous reset mid-stream at depth 3 with a pending beat
    send(IFDEF, 4'd7, 1'b1, 4'd1, "ar.p1");
    send(IFDEF, 4'd7, 1'b1, 4'd2, "ar.p2");
    send(IFDEF, 4'd7, 1'b1, 4'd3, "ar.p3");
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.vld", 32'(out_valid), 32'd0);
    chk("ar.dep", 32'(depth), 32'd0);
    chk("ar.act", 32'(out_active), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(ENDIF, 4'd0, 1'b1, 4'd0, "ar.endif");
    chk_err(1'b1, 2'd1, "ar.endif");
    send(IFDEF, 4'd7, 1'b0, 4'd1, "ar.defclr");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
